// File: rtl/mult_div_unit_pkg.sv
// Shared constants for the HI/LO multiply/divide unit.
// The hazard unit and the ID decoder use the same opcode constants.
//   NB_DATA / NB_MD_OPCODE / NB_COUNT : default widths
//   MD_MULT .. MD_DIVU                : multiply/divide opcode encodings
//   md_state_e                        : control FSM state encoding
package mult_div_unit_pkg;

    localparam int unsigned NB_DATA      = 32;
    localparam int unsigned NB_MD_OPCODE = 2;
    localparam int unsigned NB_COUNT     = 5;

    localparam logic [NB_MD_OPCODE-1:0] MD_MULT  = 2'b00;
    localparam logic [NB_MD_OPCODE-1:0] MD_MULTU = 2'b01;
    localparam logic [NB_MD_OPCODE-1:0] MD_DIV   = 2'b10;
    localparam logic [NB_MD_OPCODE-1:0] MD_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_RUN  = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

endpackage

// File: rtl/mult_div_unit_if.sv
// Pipeline-side bundle of the multiply/divide unit.
//   master : execute stage / pipeline (drives start, opcode, operands, flush, MTHI/MTLO)
//   slave  : mult_div_unit (drives HI, LO, busy, done)
interface mult_div_unit_if #(
    parameter int unsigned NB_DATA      = mult_div_unit_pkg::NB_DATA,
    parameter int unsigned NB_MD_OPCODE = mult_div_unit_pkg::NB_MD_OPCODE
);
    logic                    i_start;
    logic [NB_MD_OPCODE-1:0] i_opcode;
    logic [NB_DATA-1:0]      i_first_operator;
    logic [NB_DATA-1:0]      i_second_operator;
    logic                    i_flush;
    logic                    i_mthi;
    logic                    i_mtlo;
    logic [NB_DATA-1:0]      i_write_data;
    logic [NB_DATA-1:0]      o_hi;
    logic [NB_DATA-1:0]      o_lo;
    logic                    o_busy;
    logic                    o_done;

    modport master (
        output i_start, i_opcode, i_first_operator, i_second_operator,
        output i_flush, i_mthi, i_mtlo, i_write_data,
        input  o_hi, o_lo, o_busy, o_done
    );

    modport slave (
        input  i_start, i_opcode, i_first_operator, i_second_operator,
        input  i_flush, i_mthi, i_mtlo, i_write_data,
        output o_hi, o_lo, o_busy, o_done
    );
endinterface

// File: rtl/mult_div_unit_datapath.sv
// Unsigned iterative core of the multiply/divide unit.
// Works on operand magnitudes only; sign handling lives in the top.
//   i_clock, i_reset : clock, synchronous active-high reset
//   i_load           : capture magnitudes (a = multiplicand/dividend, b = multiplier/divisor)
//   i_step           : perform one shift-add and one restoring-divide iteration
//   i_is_div         : selects which magnitude is held as the fixed operand
//   o_product        : 2*NB_DATA accumulator value after the current step
//   o_quotient       : quotient after the current step
//   o_remainder      : remainder after the current step
// The step results are combinational so the final iteration can be written
// straight into HI/LO on the same edge.
module mult_div_unit_datapath #(
    parameter int unsigned NB_DATA = 32
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_load,
    input  logic                   i_step,
    input  logic                   i_is_div,
    input  logic [NB_DATA-1:0]     i_mag_a,
    input  logic [NB_DATA-1:0]     i_mag_b,
    output logic [2*NB_DATA-1:0]   o_product,
    output logic [NB_DATA-1:0]     o_quotient,
    output logic [NB_DATA-1:0]     o_remainder
);

    logic [NB_DATA-1:0]   operand_q;  // multiplicand or divisor
    logic [2*NB_DATA-1:0] acc_q;      // {partial product, remaining multiplier bits}
    logic [NB_DATA-1:0]   rem_q;
    logic [NB_DATA-1:0]   quo_q;      // dividend bits shift out as quotient bits shift in

    logic [NB_DATA:0]     mul_sum;
    logic [2*NB_DATA-1:0] acc_next;
    logic [NB_DATA:0]     rem_shift;
    logic [NB_DATA:0]     rem_diff;
    logic                 rem_ge;
    logic [NB_DATA-1:0]   rem_next;
    logic [NB_DATA-1:0]   quo_next;

    always_comb begin
        // Shift-add: add multiplicand when the current multiplier LSB is set, shift right.
        mul_sum  = {1'b0, acc_q[2*NB_DATA-1:NB_DATA]}
                 + (acc_q[0] ? {1'b0, operand_q} : {(NB_DATA+1){1'b0}});
        acc_next = {mul_sum, acc_q[NB_DATA-1:1]};

        // Restoring divide on an NB_DATA+1 bit partial remainder; borrow means restore.
        rem_shift = {rem_q, quo_q[NB_DATA-1]};
        rem_diff  = rem_shift - {1'b0, operand_q};
        rem_ge    = ~rem_diff[NB_DATA];
        rem_next  = rem_ge ? rem_diff[NB_DATA-1:0] : rem_shift[NB_DATA-1:0];
        quo_next  = {quo_q[NB_DATA-2:0], rem_ge};
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            operand_q <= '0;
            acc_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
        end else if (i_load) begin
            operand_q <= i_is_div ? i_mag_b : i_mag_a;
            acc_q     <= {{NB_DATA{1'b0}}, i_mag_b};
            rem_q     <= '0;
            quo_q     <= i_mag_a;
        end else if (i_step) begin
            acc_q <= acc_next;
            rem_q <= rem_next;
            quo_q <= quo_next;
        end
    end

    assign o_product   = acc_next;
    assign o_quotient  = quo_next;
    assign o_remainder = rem_next;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit for the execute stage.
//   i_clock : system clock, all state on the rising edge
//   i_reset : synchronous, active-high reset
//   bus     : mult_div_unit_if.slave
//             in : i_start, i_opcode, i_first_operator, i_second_operator,
//                  i_flush, i_mthi, i_mtlo, i_write_data
//             out: o_hi, o_lo (HI/LO registers), o_busy (RUN), o_done (one-cycle pulse)
// A start in IDLE runs NB_DATA iterations in RUN, writes HI/LO on the edge
// into DONE, then returns to IDLE.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int unsigned NB_DATA      = mult_div_unit_pkg::NB_DATA,
    parameter int unsigned NB_MD_OPCODE = mult_div_unit_pkg::NB_MD_OPCODE,
    parameter int unsigned NB_COUNT     = mult_div_unit_pkg::NB_COUNT
) (
    input  logic            i_clock,
    input  logic            i_reset,
    mult_div_unit_if.slave  bus
);

    localparam logic [NB_COUNT-1:0] LAST_ITER = NB_COUNT'(NB_DATA - 1);

    md_state_e            state_q, state_d;
    logic [NB_COUNT-1:0]  counter_q;

    logic                 is_div_q;
    logic                 neg_res_q;   // product / quotient sign
    logic                 neg_rem_q;   // remainder sign follows the dividend
    logic                 div_zero_q;
    logic [NB_DATA-1:0]   dividend_q;  // raw dividend, HI result of a divide by zero

    logic [NB_DATA-1:0]   hi_q, lo_q;
    logic [NB_DATA-1:0]   hi_bak_q, lo_bak_q;

    logic                 busy, done;
    logic                 load, step, result_we, restore, move_en;

    logic [NB_MD_OPCODE-1:0] opcode;
    logic                 op_signed, op_div, a_neg, b_neg;
    logic [NB_DATA-1:0]   mag_a, mag_b;

    logic [2*NB_DATA-1:0] product_next, product_signed;
    logic [NB_DATA-1:0]   quotient_next, quotient_signed;
    logic [NB_DATA-1:0]   remainder_next, remainder_signed;
    logic [NB_DATA-1:0]   res_hi, res_lo;

    // Operand preparation for the launch edge.
    always_comb begin
        opcode    = bus.i_opcode;
        op_signed = (opcode == MD_MULT) || (opcode == MD_DIV);
        op_div    = (opcode == MD_DIV) || (opcode == MD_DIVU);
        a_neg     = op_signed && bus.i_first_operator[NB_DATA-1];
        b_neg     = op_signed && bus.i_second_operator[NB_DATA-1];
        mag_a     = a_neg ? -bus.i_first_operator : bus.i_first_operator;
        mag_b     = b_neg ? -bus.i_second_operator : bus.i_second_operator;
    end

    // FSM: state register.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= MD_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            MD_IDLE: if (bus.i_start && !bus.i_flush) state_d = MD_RUN;
            MD_RUN: begin
                if (bus.i_flush) begin
                    state_d = MD_IDLE;
                end else if (counter_q == LAST_ITER) begin
                    state_d = MD_DONE;
                end
            end
            MD_DONE: state_d = MD_IDLE;
            default: state_d = MD_IDLE;
        endcase
    end

    // FSM: outputs. busy/done decode the registered state only.
    always_comb begin
        busy      = (state_q == MD_RUN);
        done      = (state_q == MD_DONE);
        load      = (state_q == MD_IDLE) && bus.i_start && !bus.i_flush;
        step      = busy && !bus.i_flush;
        result_we = step && (counter_q == LAST_ITER);
        restore   = done && bus.i_flush;
        // A start request in IDLE drops any simultaneous move.
        move_en   = (state_q == MD_IDLE) && !bus.i_start;
    end

    // Iteration counter and per-operation control latches.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            counter_q  <= '0;
            is_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            dividend_q <= '0;
        end else begin
            counter_q <= step ? counter_q + NB_COUNT'(1) : '0;
            if (load) begin
                is_div_q   <= op_div;
                neg_res_q  <= a_neg ^ b_neg;
                neg_rem_q  <= a_neg;
                div_zero_q <= (bus.i_second_operator == '0);
                dividend_q <= bus.i_first_operator;
            end
        end
    end

    mult_div_unit_datapath #(
        .NB_DATA (NB_DATA)
    ) u_datapath (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .i_load      (load),
        .i_step      (step),
        .i_is_div    (op_div),
        .i_mag_a     (mag_a),
        .i_mag_b     (mag_b),
        .o_product   (product_next),
        .o_quotient  (quotient_next),
        .o_remainder (remainder_next)
    );

    // Sign correction and divide-by-zero override of the final iteration.
    always_comb begin
        product_signed   = neg_res_q ? -product_next : product_next;
        quotient_signed  = neg_res_q ? -quotient_next : quotient_next;
        remainder_signed = neg_rem_q ? -remainder_next : remainder_next;
        if (!is_div_q) begin
            res_hi = product_signed[2*NB_DATA-1:NB_DATA];
            res_lo = product_signed[NB_DATA-1:0];
        end else if (div_zero_q) begin
            res_hi = dividend_q;
            res_lo = '1;
        end else begin
            res_hi = remainder_signed;
            res_lo = quotient_signed;
        end
    end

    // HI/LO. The pre-operation values are kept so a flush during DONE can
    // undo the write made on the edge into DONE.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            hi_q     <= '0;
            lo_q     <= '0;
            hi_bak_q <= '0;
            lo_bak_q <= '0;
        end else if (result_we) begin
            hi_q     <= res_hi;
            lo_q     <= res_lo;
            hi_bak_q <= hi_q;
            lo_bak_q <= lo_q;
        end else if (restore) begin
            hi_q <= hi_bak_q;
            lo_q <= lo_bak_q;
        end else if (move_en) begin
            if (bus.i_mthi) hi_q <= bus.i_write_data;
            if (bus.i_mtlo) lo_q <= bus.i_write_data;
        end
    end

    assign bus.o_hi   = hi_q;
    assign bus.o_lo   = lo_q;
    assign bus.o_busy = busy;
    assign bus.o_done = done;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit against an arithmetic reference model.
module tb_mult_div_unit;
    import mult_div_unit_pkg::*;

    logic clk;
    logic rst;

    int n_checks = 0;
    int n_fail   = 0;

    mult_div_unit_if bus ();

    mult_div_unit dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {HI, LO} from plain signed/unsigned arithmetic.
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, sb, q, m;
        logic [63:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = '0;
        case (op)
            MD_MULT:  r = 64'(sa * sb);
            MD_MULTU: r = {32'h0, a} * {32'h0, b};
            MD_DIV: begin
                if (b == 32'h0) begin
                    r = {a, 32'hFFFF_FFFF};
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    r = {32'h0, 32'h8000_0000};
                end else begin
                    q = sa / sb;
                    m = sa % sb;
                    r = {m[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 32'h0) r = {a, 32'hFFFF_FFFF};
                else            r = {a % b, a / b};
            end
        endcase
        return r;
    endfunction

    function automatic logic [31:0] rand_operand();
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0:       v = 32'h0;
            1:       v = 32'hFFFF_FFFF;
            2:       v = 32'h8000_0000;
            3:       v = 32'($urandom_range(0, 15));
            default: v = $urandom();
        endcase
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a start for one edge; returns sampling cycle 1 of the operation.
    task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.i_start           = 1'b1;
        bus.i_opcode          = op;
        bus.i_first_operator  = a;
        bus.i_second_operator = b;
        tick();
        bus.i_start = 1'b0;
    endtask

    // Walks cycles until o_done is seen (bounded); reports busy count and done cycle.
    task automatic run_to_done(input int start_cyc, output int busy_cycles,
                               output int done_cycle);
        int cyc;
        cyc         = start_cyc;
        busy_cycles = 0;
        done_cycle  = -1;
        while (cyc <= 40) begin
            if (bus.o_done) begin
                done_cycle = cyc;
                break;
            end
            if (bus.o_busy) busy_cycles++;
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_checks++; if (bus.o_hi !== 32'h0)  begin n_fail++; $display("FAIL reset_hi: got %h want 0", bus.o_hi); end
        n_checks++; if (bus.o_lo !== 32'h0)  begin n_fail++; $display("FAIL reset_lo: got %h want 0", bus.o_lo); end
        n_checks++; if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.o_busy); end
        n_checks++; if (bus.o_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.o_done); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_multu_latency();
        int busy_cycles, done_cycle;
        logic [63:0] exp;
        exp = model(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        launch(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        n_checks++; if (bus.o_busy !== 1'b1) begin n_fail++; $display("FAIL multu_busy_c1: got %b want 1", bus.o_busy); end
        run_to_done(1, busy_cycles, done_cycle);
        n_checks++; if (busy_cycles != 32) begin n_fail++; $display("FAIL multu_busy_cycles: got %0d want 32", busy_cycles); end
        n_checks++; if (done_cycle != 33) begin n_fail++; $display("FAIL multu_done_cycle: got %0d want 33", done_cycle); end
        n_checks++; if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL multu_busy_in_done: got %b want 0", bus.o_busy); end
        n_checks++; if ({bus.o_hi, bus.o_lo} !== exp) begin n_fail++; $display("FAIL multu_result: got %h want %h", {bus.o_hi, bus.o_lo}, exp); end
        n_checks++; if (bus.o_hi !== 32'hFFFF_FFFE || bus.o_lo !== 32'h0000_0001) begin n_fail++; $display("FAIL multu_const: got %h_%h want fffffffe_00000001", bus.o_hi, bus.o_lo); end
        tick();
        n_checks++; if (bus.o_done !== 1'b0) begin n_fail++; $display("FAIL multu_done_pulse: got %b want 0", bus.o_done); end
    endtask

    task automatic test_back_to_back();
        int busy_cycles, done_cycle;
        logic [63:0] exp;
        exp = model(MD_MULT, 32'hFFFF_FFFD, 32'h0000_0005);
        launch(MD_MULT, 32'hFFFF_FFFD, 32'h0000_0005);
        run_to_done(1, busy_cycles, done_cycle);
        n_checks++; if (done_cycle != 33) begin n_fail++; $display("FAIL mult_done_cycle: got %0d want 33", done_cycle); end
        n_checks++; if ({bus.o_hi, bus.o_lo} !== exp) begin n_fail++; $display("FAIL mult_neg3x5: got %h want %h", {bus.o_hi, bus.o_lo}, exp); end
        tick();  // cycle 34: IDLE, new start accepted here
        exp = model(MD_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
        launch(MD_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
        n_checks++; if (bus.o_busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy: got %b want 1", bus.o_busy); end
        run_to_done(1, busy_cycles, done_cycle);
        n_checks++; if (done_cycle != 33) begin n_fail++; $display("FAIL div_done_cycle: got %0d want 33", done_cycle); end
        n_checks++; if ({bus.o_hi, bus.o_lo} !== exp) begin n_fail++; $display("FAIL div_neg7by2: got %h want %h", {bus.o_hi, bus.o_lo}, exp); end
        n_checks++; if (bus.o_lo !== 32'hFFFF_FFFD || bus.o_hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_neg7by2_const: got %h_%h want ffffffff_fffffffd", bus.o_hi, bus.o_lo); end
        tick();
    endtask

    task automatic test_div_corners();
        int busy_cycles, done_cycle;
        launch(MD_DIVU, 32'h0000_0007, 32'h0);
        run_to_done(1, busy_cycles, done_cycle);
        n_checks++; if (done_cycle != 33) begin n_fail++; $display("FAIL divz_done_cycle: got %0d want 33", done_cycle); end
        n_checks++; if (bus.o_hi !== 32'h7 || bus.o_lo !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL divu_by_zero: got %h_%h want 00000007_ffffffff", bus.o_hi, bus.o_lo); end
        tick();
        launch(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        run_to_done(1, busy_cycles, done_cycle);
        n_checks++; if (bus.o_hi !== 32'h0 || bus.o_lo !== 32'h8000_0000) begin n_fail++; $display("FAIL div_overflow: got %h_%h want 00000000_80000000", bus.o_hi, bus.o_lo); end
        tick();
        launch(MD_DIV, 32'hFFFF_FFF0, 32'h0);
        run_to_done(1, busy_cycles, done_cycle);
        n_checks++; if (bus.o_hi !== 32'hFFFF_FFF0 || bus.o_lo !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_neg_by_zero: got %h_%h want fffffff0_ffffffff", bus.o_hi, bus.o_lo); end
        tick();
    endtask

    task automatic test_flush();
        int busy_cycles, done_cycle;
        bit saw_done;
        bus.i_mthi = 1'b1; bus.i_mtlo = 1'b1; bus.i_write_data = 32'h55AA_33CC;
        tick();
        bus.i_mthi = 1'b0; bus.i_mtlo = 1'b0;
        n_checks++; if (bus.o_hi !== 32'h55AA_33CC || bus.o_lo !== 32'h55AA_33CC) begin n_fail++; $display("FAIL mthi_mtlo_both: got %h_%h want 55aa33cc_55aa33cc", bus.o_hi, bus.o_lo); end
        bus.i_mthi = 1'b1; bus.i_write_data = 32'h1234_5678;
        tick();
        bus.i_mthi = 1'b0; bus.i_mtlo = 1'b1; bus.i_write_data = 32'h9ABC_DEF0;
        tick();
        bus.i_mtlo = 1'b0;
        n_checks++; if (bus.o_hi !== 32'h1234_5678 || bus.o_lo !== 32'h9ABC_DEF0) begin n_fail++; $display("FAIL mthi_mtlo: got %h_%h want 12345678_9abcdef0", bus.o_hi, bus.o_lo); end
        launch(MD_MULT, 32'h0000_1234, 32'hFFFF_0003);
        for (int c = 1; c < 10; c++) tick();
        bus.i_flush = 1'b1;  // cycle 10
        tick();
        bus.i_flush = 1'b0;
        n_checks++; if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy_c11: got %b want 0", bus.o_busy); end
        saw_done = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (bus.o_done) saw_done = 1'b1;
            tick();
        end
        n_checks++; if (saw_done !== 1'b0) begin n_fail++; $display("FAIL flush_no_done: got %b want 0", saw_done); end
        n_checks++; if (bus.o_hi !== 32'h1234_5678 || bus.o_lo !== 32'h9ABC_DEF0) begin n_fail++; $display("FAIL flush_run_keep: got %h_%h want 12345678_9abcdef0", bus.o_hi, bus.o_lo); end
        // Flush during DONE undoes the result write.
        launch(MD_MULTU, 32'h0001_0001, 32'h0000_0003);
        run_to_done(1, busy_cycles, done_cycle);
        n_checks++; if (done_cycle != 33) begin n_fail++; $display("FAIL flush_done_cycle: got %0d want 33", done_cycle); end
        bus.i_flush = 1'b1;
        tick();
        bus.i_flush = 1'b0;
        n_checks++; if (bus.o_done !== 1'b0 || bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL flush_done_ctrl: got done=%b busy=%b want 0 0", bus.o_done, bus.o_busy); end
        n_checks++; if (bus.o_hi !== 32'h1234_5678 || bus.o_lo !== 32'h9ABC_DEF0) begin n_fail++; $display("FAIL flush_done_keep: got %h_%h want 12345678_9abcdef0", bus.o_hi, bus.o_lo); end
        // Start and flush together in IDLE: nothing launches.
        bus.i_start = 1'b1; bus.i_flush = 1'b1; bus.i_opcode = MD_MULTU;
        tick();
        bus.i_start = 1'b0; bus.i_flush = 1'b0;
        n_checks++; if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL start_flush_idle: got busy=%b want 0", bus.o_busy); end
        tick();
    endtask

    task automatic test_ignore_during_run();
        int busy_cycles, done_cycle;
        logic [31:0] a, b;
        logic [63:0] exp;
        a = $urandom();
        b = 32'($urandom_range(1, 32'h0000_FFFF));
        exp = model(MD_DIVU, a, b);
        launch(MD_DIVU, a, b);
        for (int c = 1; c < 5; c++) tick();
        bus.i_start = 1'b1;  // held from cycle 5 through DONE
        bus.i_opcode = MD_MULT;
        bus.i_first_operator = 32'h0000_0077;
        bus.i_second_operator = 32'h0000_0099;
        bus.i_mtlo = 1'b1; bus.i_write_data = 32'hDEAD_BEEF;
        tick();
        bus.i_mtlo = 1'b0;
        run_to_done(6, busy_cycles, done_cycle);
        n_checks++; if (done_cycle != 33) begin n_fail++; $display("FAIL ignore_done_cycle: got %0d want 33", done_cycle); end
        n_checks++; if ({bus.o_hi, bus.o_lo} !== exp) begin n_fail++; $display("FAIL ignore_result: got %h want %h", {bus.o_hi, bus.o_lo}, exp); end
        tick();
        bus.i_start = 1'b0;
        n_checks++; if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL start_in_done_ignored: got busy=%b want 0", bus.o_busy); end
        tick();
    endtask

    task automatic test_reset_mid_op();
        int busy_cycles, done_cycle;
        logic [63:0] exp;
        bus.i_mthi = 1'b1; bus.i_mtlo = 1'b1; bus.i_write_data = 32'hC0FF_EE11;
        tick();
        bus.i_mthi = 1'b0; bus.i_mtlo = 1'b0;
        launch(MD_DIV, 32'h8765_4321, 32'h0000_0123);
        for (int c = 1; c < 15; c++) tick();
        rst = 1'b1;  // cycle 15
        tick();
        rst = 1'b0;
        n_checks++; if (bus.o_busy !== 1'b0 || bus.o_done !== 1'b0) begin n_fail++; $display("FAIL midreset_ctrl: got busy=%b done=%b want 0 0", bus.o_busy, bus.o_done); end
        n_checks++; if (bus.o_hi !== 32'h0 || bus.o_lo !== 32'h0) begin n_fail++; $display("FAIL midreset_hilo: got %h_%h want 0_0", bus.o_hi, bus.o_lo); end
        tick();
        exp = model(MD_DIV, 32'hFFFF_1000, 32'h0000_0007);
        launch(MD_DIV, 32'hFFFF_1000, 32'h0000_0007);
        run_to_done(1, busy_cycles, done_cycle);
        n_checks++; if (done_cycle != 33 || busy_cycles != 32) begin n_fail++; $display("FAIL postreset_latency: got done=%0d busy=%0d want 33 32", done_cycle, busy_cycles); end
        n_checks++; if ({bus.o_hi, bus.o_lo} !== exp) begin n_fail++; $display("FAIL postreset_result: got %h want %h", {bus.o_hi, bus.o_lo}, exp); end
        tick();
    endtask

    task automatic test_random();
        int busy_cycles, done_cycle;
        logic [1:0]  op;
        logic [31:0] a, b;
        logic [63:0] exp;
        for (int i = 0; i < 24; i++) begin
            op  = 2'($urandom_range(0, 3));
            a   = rand_operand();
            b   = rand_operand();
            exp = model(op, a, b);
            launch(op, a, b);
            run_to_done(1, busy_cycles, done_cycle);
            n_checks++; if (done_cycle != 33 || busy_cycles != 32) begin n_fail++; $display("FAIL rand_latency[%0d]: got done=%0d busy=%0d want 33 32", i, done_cycle, busy_cycles); end
            n_checks++; if ({bus.o_hi, bus.o_lo} !== exp) begin n_fail++; $display("FAIL rand_result[%0d] op=%0d a=%h b=%h: got %h want %h", i, op, a, b, {bus.o_hi, bus.o_lo}, exp); end
            tick();
        end
    endtask

    initial begin
        rst                   = 1'b1;
        bus.i_start           = 1'b0;
        bus.i_opcode          = MD_MULT;
        bus.i_first_operator  = '0;
        bus.i_second_operator = '0;
        bus.i_flush           = 1'b0;
        bus.i_mthi            = 1'b0;
        bus.i_mtlo            = 1'b0;
        bus.i_write_data      = '0;

        test_reset();
        test_multu_latency();
        test_back_to_back();
        test_div_corners();
        test_flush();
        test_ignore_during_run();
        test_reset_mid_op();
        test_random();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
